// File: rtl/tape_rec.sv
// tape_rec: cassette recorder. Samples the ULA MIC level, measures the time
// between level changes in sample ticks and encodes each pulse as a CSW-v1
// RLE byte stream. Bytes are buffered in a small FIFO and written to SDRAM
// one byte per Z80 refresh window (nRFSH low).
//
// Ports:
//   clk_cpu   CPU clock, rising edge
//   nRESET    asynchronous active-low reset
//   enable    record request (level)
//   mic       ULA MIC level (asynchronous)
//   nRFSH     Z80 refresh strobe, low marks a free SDRAM slot
//   mem_wr    write request for the current refresh window
//   mem_addr  BASE + size
//   mem_din   FIFO head byte
//   busy      recording or flushing (registered)
//   size      bytes committed to SDRAM
//   overflow  sticky, data was lost
//   full      sticky, MAXLEN bytes were written
module tape_rec #(
    parameter int unsigned DIV     = 80,
    parameter logic [24:0] BASE    = 25'h0400000,
    parameter logic [24:0] MAXLEN  = 25'h0100000,
    parameter int unsigned FIFO_AW = 4
) (
    input  logic        clk_cpu,
    input  logic        nRESET,
    input  logic        enable,
    input  logic        mic,
    input  logic        nRFSH,
    output logic        mem_wr,
    output logic [24:0] mem_addr,
    output logic [7:0]  mem_din,
    output logic        busy,
    output logic [24:0] size,
    output logic        overflow,
    output logic        full
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned PW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
    localparam logic [FIFO_AW:0] FIFO_DEPTH = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {StIdle, StArm, StCount, StFlush, StDrain} state_e;

    state_e              state_q;
    logic                mic_s1_q, mic_s2_q, mic_prev_q;
    logic [PW-1:0]       presc_q;
    logic [31:0]         len_q;
    logic [31:0]         cap_q;
    logic                cap_v_q;
    logic [2:0]          emit_idx_q;
    logic [7:0]          fifo_mem_q [DEPTH];
    logic [FIFO_AW-1:0]  wptr_q, rptr_q;
    logic [FIFO_AW:0]    cnt_q;
    logic [24:0]         size_q;
    logic                overflow_q, full_q, done_win_q, busy_q;

    logic        mic_edge, presc_wrap;
    logic [31:0] len_inc, len_now, cap_new;
    logic [7:0]  push_byte;
    logic        emit_last, cap_short;
    logic        fifo_empty, fifo_full;
    logic        commit, push_req, push_ok, push_drop;

    assign mic_edge   = mic_s2_q ^ mic_prev_q;
    assign presc_wrap = (presc_q == PRESC_MAX);
    assign len_inc    = (&len_q) ? len_q : len_q + 32'd1;
    // Length including the tick that may complete in this very cycle.
    assign len_now    = presc_wrap ? len_inc : len_q;
    assign cap_new    = (len_now == 32'd0) ? 32'd1 : len_now;
    assign cap_short  = (cap_q[31:8] == 24'd0);

    // Long pulses are a zero marker followed by the 32-bit length, LSB first.
    always_comb begin
        push_byte = cap_q[7:0];
        emit_last = 1'b1;
        if (!cap_short) begin
            unique case (emit_idx_q)
                3'd0: begin push_byte = 8'h00;        emit_last = 1'b0; end
                3'd1: begin push_byte = cap_q[7:0];   emit_last = 1'b0; end
                3'd2: begin push_byte = cap_q[15:8];  emit_last = 1'b0; end
                3'd3: begin push_byte = cap_q[23:16]; emit_last = 1'b0; end
                default: begin push_byte = cap_q[31:24]; emit_last = 1'b1; end
            endcase
        end
    end

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == FIFO_DEPTH);
    assign mem_wr     = !fifo_empty && !full_q && !done_win_q;
    assign commit     = mem_wr && !nRFSH;
    // Once full, the emitter keeps running but its bytes go nowhere.
    assign push_req   = cap_v_q && !full_q;
    assign push_ok    = push_req && !fifo_full;
    assign push_drop  = push_req && fifo_full;

    assign mem_addr = BASE + size_q;
    assign mem_din  = fifo_empty ? 8'h00 : fifo_mem_q[rptr_q];
    assign busy     = busy_q;
    assign size     = size_q;
    assign overflow = overflow_q;
    assign full     = full_q;

    always_ff @(posedge clk_cpu or negedge nRESET) begin
        if (!nRESET) begin
            mic_s1_q   <= 1'b0;
            mic_s2_q   <= 1'b0;
            mic_prev_q <= 1'b0;
        end else begin
            mic_s1_q   <= mic;
            mic_s2_q   <= mic_s1_q;
            mic_prev_q <= mic_s2_q;
        end
    end

    always_ff @(posedge clk_cpu or negedge nRESET) begin
        if (!nRESET) begin
            state_q    <= StIdle;
            presc_q    <= '0;
            len_q      <= '0;
            cap_q      <= '0;
            cap_v_q    <= 1'b0;
            emit_idx_q <= '0;
            for (int i = 0; i < DEPTH; i++) fifo_mem_q[i] <= 8'h00;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            size_q     <= '0;
            overflow_q <= 1'b0;
            full_q     <= 1'b0;
            done_win_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            if (presc_wrap) begin
                presc_q <= '0;
                len_q   <= len_inc;
            end else begin
                presc_q <= presc_q + 1'b1;
            end

            if (nRFSH) done_win_q <= 1'b0;

            if (cap_v_q) begin
                if (emit_last) begin
                    cap_v_q    <= 1'b0;
                    emit_idx_q <= '0;
                end else begin
                    emit_idx_q <= emit_idx_q + 3'd1;
                end
            end

            if (push_ok) begin
                fifo_mem_q[wptr_q] <= push_byte;
                wptr_q <= wptr_q + 1'b1;
            end
            if (push_drop) overflow_q <= 1'b1;

            if (commit) begin
                rptr_q     <= rptr_q + 1'b1;
                size_q     <= size_q + 25'd1;
                done_win_q <= 1'b1;
                if (size_q + 25'd1 == MAXLEN) full_q <= 1'b1;
            end

            if (push_ok && !commit) cnt_q <= cnt_q + 1'b1;
            else if (!push_ok && commit) cnt_q <= cnt_q - 1'b1;

            unique case (state_q)
                StIdle: begin
                    if (enable) begin
                        state_q    <= StArm;
                        busy_q     <= 1'b1;
                        size_q     <= '0;
                        overflow_q <= 1'b0;
                        full_q     <= 1'b0;
                        wptr_q     <= '0;
                        rptr_q     <= '0;
                        cnt_q      <= '0;
                        cap_v_q    <= 1'b0;
                        emit_idx_q <= '0;
                    end
                end
                StArm: begin
                    if (!enable) begin
                        state_q <= StDrain;
                    end else if (mic_edge) begin
                        len_q   <= '0;
                        presc_q <= '0;
                        state_q <= StCount;
                    end
                end
                StCount: begin
                    if (!enable) begin
                        state_q <= StFlush;
                    end else if (mic_edge) begin
                        len_q   <= '0;
                        presc_q <= '0;
                        if (cap_v_q) begin
                            overflow_q <= 1'b1;
                        end else begin
                            cap_q      <= cap_new;
                            cap_v_q    <= 1'b1;
                            emit_idx_q <= '0;
                        end
                    end
                end
                StFlush: begin
                    if (len_q != 32'd0) begin
                        if (cap_v_q) begin
                            overflow_q <= 1'b1;
                        end else begin
                            cap_q      <= len_q;
                            cap_v_q    <= 1'b1;
                            emit_idx_q <= '0;
                        end
                    end
                    state_q <= StDrain;
                end
                StDrain: begin
                    if (!cap_v_q && (fifo_empty || full_q)) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tape_rec.sv
module tb_tape_rec;

    localparam int unsigned DIV  = 4;
    localparam logic [24:0] BASE = 25'h0400000;

    logic        clk_cpu = 1'b0;
    logic        nRESET, enable, mic, nRFSH;
    logic        mem_wr, busy, overflow, full;
    logic [24:0] mem_addr, size;
    logic [7:0]  mem_din;
    logic        c_mem_wr, c_busy, c_overflow, c_full;
    logic [24:0] c_mem_addr, c_size;
    logic [7:0]  c_mem_din;

    tape_rec #(.DIV(DIV), .BASE(BASE), .MAXLEN(25'h0100000), .FIFO_AW(4)) dut (
        .clk_cpu(clk_cpu), .nRESET(nRESET), .enable(enable), .mic(mic), .nRFSH(nRFSH),
        .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_din(mem_din), .busy(busy),
        .size(size), .overflow(overflow), .full(full)
    );

    tape_rec #(.DIV(DIV), .BASE(BASE), .MAXLEN(25'd3), .FIFO_AW(4)) dut_cap (
        .clk_cpu(clk_cpu), .nRESET(nRESET), .enable(enable), .mic(mic), .nRFSH(nRFSH),
        .mem_wr(c_mem_wr), .mem_addr(c_mem_addr), .mem_din(c_mem_din), .busy(c_busy),
        .size(c_size), .overflow(c_overflow), .full(c_full)
    );

    always #5 clk_cpu = ~clk_cpu;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int rfsh_mode  = 0;   // 0: nRFSH high, 1: low one cycle in eight, 2: driven by hand
    int cap_commits = 0;

    logic [24:0]  wr_addr_q[$];
    logic [7:0]   wr_data_q[$];
    logic [7:0]   exp_q[$];
    int unsigned  gaps[$];
    int           wr_base;
    int           cap_base;

    // SDRAM side: a byte is taken at the edge following a cycle with mem_wr && !nRFSH.
    always @(negedge clk_cpu) begin
        if (nRESET && mem_wr && !nRFSH) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_din);
        end
    end

    always @(negedge clk_cpu) begin
        if (nRESET && c_mem_wr && !nRFSH) cap_commits++;
    end

    task automatic tick();
        @(posedge clk_cpu);
        #2;
        cyc++;
        if (rfsh_mode == 1) nRFSH = ((cyc % 8) != 0);
        else if (rfsh_mode == 0) nRFSH = 1'b1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    // CSW-v1 encoding of one pulse measured in whole sample ticks.
    function automatic void encode(input int unsigned ticks);
        logic [31:0] v;
        v = (ticks == 0) ? 32'd1 : ticks;
        if (v <= 32'd255) begin
            exp_q.push_back(v[7:0]);
        end else begin
            exp_q.push_back(8'h00);
            exp_q.push_back(v[7:0]);
            exp_q.push_back(v[15:8]);
            exp_q.push_back(v[23:16]);
            exp_q.push_back(v[31:24]);
        end
    endfunction

    task automatic begin_test();
        gaps.delete();
        exp_q.delete();
        wr_base  = wr_data_q.size();
        cap_base = cap_commits;
    endtask

    // Arms, plays the edge gaps (in clocks) and drops enable kflush ticks after
    // the last edge (plus a small offset so the tick count is unambiguous).
    task automatic record(input int unsigned kflush);
        enable = 1'b1;
        repeat (4) tick();
        mic = ~mic;
        foreach (gaps[i]) begin
            repeat (gaps[i]) tick();
            mic = ~mic;
            encode(gaps[i] / DIV);
        end
        repeat (DIV * kflush + 3) tick();
        enable = 1'b0;
        if (kflush != 0) encode(kflush);
    endtask

    task automatic wait_idle(input string tag);
        int i;
        for (i = 0; i < 5000; i++) begin
            if (!busy && !c_busy) break;
            tick();
        end
        check({tag, "_idle_timeout"}, {31'd0, busy | c_busy}, 32'd0);
    endtask

    task automatic finish_rec(input string tag, input int nexp);
        int n;
        rfsh_mode = 1;
        wait_idle(tag);
        repeat (2) tick();
        n = wr_data_q.size() - wr_base;
        check({tag, "_count"}, n, nexp);
        for (int i = 0; i < nexp && i < n; i++) begin
            check($sformatf("%s_data%0d", tag, i), {24'd0, wr_data_q[wr_base + i]},
                  {24'd0, exp_q[i]});
            check($sformatf("%s_addr%0d", tag, i), {7'd0, wr_addr_q[wr_base + i]},
                  {7'd0, BASE} + i);
        end
        check({tag, "_size"}, {7'd0, size}, nexp);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_mem_wr"}, {31'd0, mem_wr}, 32'd0);
        check({tag, "_mem_addr"}, {7'd0, mem_addr}, {7'd0, BASE});
        check({tag, "_mem_din"}, {24'd0, mem_din}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_size"}, {7'd0, size}, 32'd0);
        check({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
        check({tag, "_full"}, {31'd0, full}, 32'd0);
    endtask

    initial begin
        int i;
        nRESET = 1'b0;
        enable = 1'b0;
        mic    = 1'b0;
        nRFSH  = 1'b1;
        repeat (3) tick();
        check_reset("rst_hold");
        nRESET = 1'b1;
        repeat (3) tick();
        check_reset("rst_idle");

        // Short pulses: 20 clocks = 5 ticks each.
        begin_test();
        rfsh_mode = 1;
        gaps.push_back(20);
        gaps.push_back(20);
        record(0);
        finish_rec("short", exp_q.size());
        check("short_overflow", {31'd0, overflow}, 32'd0);

        // Long pulse: 300 ticks needs the five-byte form.
        begin_test();
        gaps.push_back(1200);
        record(0);
        check("long_exp_len", exp_q.size(), 5);
        finish_rec("long", exp_q.size());

        // Final pulse captured on flush.
        begin_test();
        gaps.push_back(20);
        record(100);
        finish_rec("flush", exp_q.size());

        // Window rule: one commit per nRFSH low window.
        begin_test();
        rfsh_mode = 0;
        gaps.push_back(20);
        gaps.push_back(20);
        record(0);
        rfsh_mode = 2;
        repeat (6) tick();
        check("win_wr_before", {31'd0, mem_wr}, 32'd1);
        check("win_din_before", {24'd0, mem_din}, 32'h05);
        check("win_addr_before", {7'd0, mem_addr}, {7'd0, BASE});
        nRFSH = 1'b0;
        tick();
        check("win_wr_low0", {31'd0, mem_wr}, 32'd0);
        check("win_size_low0", {7'd0, size}, 32'd1);
        check("win_addr_low0", {7'd0, mem_addr}, {7'd0, BASE} + 1);
        tick();
        tick();
        check("win_wr_low2", {31'd0, mem_wr}, 32'd0);
        check("win_commits", wr_data_q.size() - wr_base, 1);
        nRFSH = 1'b1;
        tick();
        check("win_wr_after", {31'd0, mem_wr}, 32'd1);
        finish_rec("win", exp_q.size());

        // Random mix of short and long pulses.
        begin_test();
        for (i = 0; i < 8; i++) gaps.push_back(DIV * $urandom_range(1, 700) + 2);
        record($urandom_range(1, 80));
        finish_rec("rand", exp_q.size());
        check("rand_overflow", {31'd0, overflow}, 32'd0);

        // FIFO overflow with no refresh slots: only the first 16 bytes survive.
        begin_test();
        rfsh_mode = 0;
        for (i = 0; i < 18; i++) gaps.push_back(DIV * $urandom_range(1, 20) + 2);
        record(0);
        repeat (4) tick();
        check("ovf_flag", {31'd0, overflow}, 32'd1);
        check("ovf_nowrite", wr_data_q.size() - wr_base, 0);
        finish_rec("ovf", 16);

        // Capacity limit on the MAXLEN=3 instance.
        begin_test();
        rfsh_mode = 1;
        for (i = 0; i < 5; i++) gaps.push_back(20);
        record(0);
        check("cap_full", {31'd0, c_full}, 32'd1);
        check("cap_size", {7'd0, c_size}, 32'd3);
        check("cap_wr", {31'd0, c_mem_wr}, 32'd0);
        finish_rec("capmain", exp_q.size());
        check("cap_commits", cap_commits - cap_base, 3);
        check("cap_busy", {31'd0, c_busy}, 32'd0);
        check("cap_size_end", {7'd0, c_size}, 32'd3);

        // Reset during the third byte of a five-byte emission.
        begin_test();
        rfsh_mode = 0;
        enable = 1'b1;
        repeat (4) tick();
        mic = ~mic;
        repeat (1200) tick();
        mic = ~mic;
        repeat (5) tick();
        nRESET = 1'b0;
        #1;
        check_reset("rst_mid");
        enable = 1'b0;
        repeat (3) tick();
        nRESET = 1'b1;
        rfsh_mode = 1;
        repeat (40) tick();
        check("rst_nowrite", wr_data_q.size() - wr_base, 0);
        check_reset("rst_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
